// File: rtl/game_pkg.sv
// Shared screen, key and stage-complete selection codes for the game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    SCR_MENU     = 3'd0,
    SCR_PLAY     = 3'd1,
    SCR_COMPLETE = 3'd2,
    SCR_GAMEOVER = 3'd3,
    SCR_ALLCLEAR = 3'd4
  } screen_t;

  localparam logic [4:0] KEY_SEL  = 5'h1d;
  localparam logic [4:0] KEY_MOVE = 5'h1e;

  localparam logic [1:0] SEL_RESTART = 2'b00;
  localparam logic [1:0] SEL_MENU    = 2'b01;
  localparam logic [1:0] SEL_NEXT    = 2'b10;
  localparam logic [1:0] SEL_NONE    = 2'b11;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the play/screen logic and the game flow controller.
// Handshake: every input is a single-cycle qualifier sampled on the rising clock
// edge with no backpressure; outputs are registered except the rgb mux.
interface game_flow_ctrl_if;
  logic [4:0] key_pulse;
  logic       stage_clear;
  logic       game_over;
  logic [1:0] complete_sel;
  logic [2:0] rgb_menu;
  logic [2:0] rgb_play;
  logic [2:0] rgb_complete;
  logic [2:0] rgb_over;
  logic [2:0] rgb_clear;
  logic [2:0] screen;
  logic [1:0] stage;
  logic       stage_load;
  logic       sub_rst;
  logic [2:0] rgb;

  modport master (
    output key_pulse, stage_clear, game_over, complete_sel,
    output rgb_menu, rgb_play, rgb_complete, rgb_over, rgb_clear,
    input  screen, stage, stage_load, sub_rst, rgb
  );

  modport slave (
    input  key_pulse, stage_clear, game_over, complete_sel,
    input  rgb_menu, rgb_play, rgb_complete, rgb_over, rgb_clear,
    output screen, stage, stage_load, sub_rst, rgb
  );
endinterface

// File: rtl/holdoff_timer.sv
// Reload/decrement counter that masks user input for HOLDOFF cycles after a screen change.
module holdoff_timer #(
  parameter int HOLDOFF = 2500000,
  parameter int HW      = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic ready
);

  localparam logic [HW-1:0] INIT = HW'(HOLDOFF);
  localparam logic [HW-1:0] ONE  = HW'(1);

  logic [HW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= INIT;
    end else if (load) begin
      cnt <= INIT;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign ready = (cnt == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Screen/stage sequencer: tracks the active screen and stage, pulses level loads
// and sub-screen resets, and selects the active screen's pixel colour.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int HOLDOFF    = 2500000,
  parameter int HW         = 22
) (
  input  logic               clk,
  input  logic               rst,
  game_flow_ctrl_if.slave    bus
);

  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);
  localparam logic [1:0] STAGE_ONE  = 2'd1;

  screen_t    scr, nxt_scr;
  logic [1:0] stg, nxt_stg;
  logic       nxt_load;
  logic       chg;
  logic       ready;
  logic       load_q, sub_rst_q;
  logic       key_sel;

  assign key_sel = ready && (bus.key_pulse == KEY_SEL);

  // Next-state decode; the register block below is the only state holder.
  always_comb begin
    nxt_scr  = scr;
    nxt_stg  = stg;
    nxt_load = 1'b0;
    case (scr)
      SCR_MENU: begin
        if (key_sel) begin
          nxt_scr  = SCR_PLAY;
          nxt_stg  = '0;
          nxt_load = 1'b1;
        end
      end
      SCR_PLAY: begin
        if (bus.game_over) begin
          nxt_scr = SCR_GAMEOVER;
        end else if (bus.stage_clear) begin
          nxt_scr = (stg == LAST_STAGE) ? SCR_ALLCLEAR : SCR_COMPLETE;
        end
      end
      SCR_COMPLETE: begin
        if (ready) begin
          case (bus.complete_sel)
            SEL_RESTART: begin
              nxt_scr  = SCR_PLAY;
              nxt_load = 1'b1;
            end
            SEL_MENU: nxt_scr = SCR_MENU;
            SEL_NEXT: begin
              // Next on the last stage degrades to a restart.
              nxt_scr  = SCR_PLAY;
              nxt_load = 1'b1;
              if (stg != LAST_STAGE) nxt_stg = stg + STAGE_ONE;
            end
            default: ;
          endcase
        end
      end
      SCR_GAMEOVER: begin
        if (key_sel) nxt_scr = SCR_MENU;
      end
      SCR_ALLCLEAR: begin
        if (key_sel) begin
          nxt_scr = SCR_MENU;
          nxt_stg = '0;
        end
      end
      default: nxt_scr = SCR_MENU;
    endcase
  end

  assign chg = (nxt_scr != scr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr       <= SCR_MENU;
      stg       <= '0;
      load_q    <= 1'b0;
      sub_rst_q <= 1'b1;
    end else begin
      scr       <= nxt_scr;
      stg       <= nxt_stg;
      load_q    <= nxt_load;
      sub_rst_q <= chg;
    end
  end

  holdoff_timer #(
    .HOLDOFF (HOLDOFF),
    .HW      (HW)
  ) u_holdoff (
    .clk   (clk),
    .rst   (rst),
    .load  (chg),
    .ready (ready)
  );

  always_comb begin
    bus.rgb = 3'b000;
    case (scr)
      SCR_MENU:     bus.rgb = bus.rgb_menu;
      SCR_PLAY:     bus.rgb = bus.rgb_play;
      SCR_COMPLETE: bus.rgb = bus.rgb_complete;
      SCR_GAMEOVER: bus.rgb = bus.rgb_over;
      SCR_ALLCLEAR: bus.rgb = bus.rgb_clear;
      default:      bus.rgb = 3'b000;
    endcase
  end

  assign bus.screen     = scr;
  assign bus.stage      = stg;
  assign bus.stage_load = load_q;
  assign bus.sub_rst    = sub_rst_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with HOLDOFF=4, NUM_STAGES=3.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int W = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] exp_q[$];
  logic [2:0]   rgb_tab[0:7];

  game_flow_ctrl_if bus();

  game_flow_ctrl #(
    .NUM_STAGES (3),
    .HOLDOFF    (4),
    .HW         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: hold inputs for one sampling edge, then return them to idle.
  task automatic cycle_in(input logic [4:0] k, input logic sc, input logic go, input logic [1:0] sel);
    bus.key_pulse    = k;
    bus.stage_clear  = sc;
    bus.game_over    = go;
    bus.complete_sel = sel;
    @(posedge clk);
    #1;
    bus.key_pulse    = 5'h00;
    bus.stage_clear  = 1'b0;
    bus.game_over    = 1'b0;
    bus.complete_sel = SEL_NONE;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(5'h00, 1'b0, 1'b0, SEL_NONE);
  endtask

  // Scoreboard: snapshot is {screen, stage, stage_load, sub_rst, rgb}.
  task automatic expect_snap(input string tag, input logic [2:0] scr, input logic [1:0] stg,
                             input logic ld, input logic sr);
    logic [W-1:0] exp;
    exp_q.push_back({scr, stg, ld, sr, rgb_tab[scr]});
    exp = exp_q.pop_front();
    check(tag, {bus.screen, bus.stage, bus.stage_load, bus.sub_rst, bus.rgb}, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rgb_tab[0] = 3'd1; rgb_tab[1] = 3'd2; rgb_tab[2] = 3'd3; rgb_tab[3] = 3'd5;
    rgb_tab[4] = 3'd6; rgb_tab[5] = 3'd0; rgb_tab[6] = 3'd0; rgb_tab[7] = 3'd0;
    bus.rgb_menu     = 3'd1;
    bus.rgb_play     = 3'd2;
    bus.rgb_complete = 3'd3;
    bus.rgb_over     = 3'd5;
    bus.rgb_clear    = 3'd6;
    bus.key_pulse    = 5'h00;
    bus.stage_clear  = 1'b0;
    bus.game_over    = 1'b0;
    bus.complete_sel = SEL_NONE;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_snap("reset", 3'd0, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;

    // Menu hold-off after reset
    idle(1);
    expect_snap("rst_release", 3'd0, 2'd0, 1'b0, 1'b0);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("menu_hold_early", 3'd0, 2'd0, 1'b0, 1'b0);
    idle(1);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("menu_hold_last", 3'd0, 2'd0, 1'b0, 1'b0);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("menu_start", 3'd1, 2'd0, 1'b1, 1'b1);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("play_key_ignored", 3'd1, 2'd0, 1'b0, 1'b0);

    // Stage 0 -> complete -> next
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    expect_snap("clear_s0", 3'd2, 2'd0, 1'b0, 1'b1);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NEXT);
    expect_snap("sel_hold_early", 3'd2, 2'd0, 1'b0, 1'b0);
    idle(2);
    cycle_in(5'h00, 1'b1, 1'b1, SEL_NEXT);
    expect_snap("sel_hold_last", 3'd2, 2'd0, 1'b0, 1'b0);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NONE);
    expect_snap("sel_none_stay", 3'd2, 2'd0, 1'b0, 1'b0);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NEXT);
    expect_snap("next_s1", 3'd1, 2'd1, 1'b1, 1'b1);
    idle(1);
    expect_snap("load_once", 3'd1, 2'd1, 1'b0, 1'b0);

    // Stage 1: restart, then back to menu
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    expect_snap("clear_s1", 3'd2, 2'd1, 1'b0, 1'b1);
    idle(4);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_RESTART);
    expect_snap("restart_s1", 3'd1, 2'd1, 1'b1, 1'b1);
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    expect_snap("clear_s1b", 3'd2, 2'd1, 1'b0, 1'b1);
    idle(4);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_MENU);
    expect_snap("menu_from_complete", 3'd0, 2'd1, 1'b0, 1'b1);
    cycle_in(5'h00, 1'b1, 1'b1, SEL_NONE);
    expect_snap("menu_ignores_play", 3'd0, 2'd1, 1'b0, 1'b0);
    idle(3);
    cycle_in(KEY_MOVE, 1'b0, 1'b0, SEL_NONE);
    expect_snap("move_ignored", 3'd0, 2'd1, 1'b0, 1'b0);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("menu_to_play", 3'd1, 2'd0, 1'b1, 1'b1);

    // Walk to the last stage and all clear
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    idle(4);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NEXT);
    expect_snap("walk_s1", 3'd1, 2'd1, 1'b1, 1'b1);
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    idle(4);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NEXT);
    expect_snap("next_s2", 3'd1, 2'd2, 1'b1, 1'b1);
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    expect_snap("allclear", 3'd4, 2'd2, 1'b0, 1'b1);
    idle(3);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("allclear_hold", 3'd4, 2'd2, 1'b0, 1'b0);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("allclear_exit", 3'd0, 2'd0, 1'b0, 1'b1);

    // Game over has priority over stage clear
    idle(4);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("play_again", 3'd1, 2'd0, 1'b1, 1'b1);
    cycle_in(5'h00, 1'b1, 1'b1, SEL_NONE);
    expect_snap("over_wins", 3'd3, 2'd0, 1'b0, 1'b1);
    idle(4);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    expect_snap("over_exit", 3'd0, 2'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of stage 1
    idle(4);
    cycle_in(KEY_SEL, 1'b0, 1'b0, SEL_NONE);
    cycle_in(5'h00, 1'b1, 1'b0, SEL_NONE);
    idle(4);
    cycle_in(5'h00, 1'b0, 1'b0, SEL_NEXT);
    idle(1);
    expect_snap("pre_rst_play", 3'd1, 2'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    expect_snap("async_rst", 3'd0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    expect_snap("rst_hold", 3'd0, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    expect_snap("rst_release2", 3'd0, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level screen/stage sequencer that sits directly downstream of the stage-complete screen and consumes its 2-bit selection code (restart/menu/next/none).
- Tracks which screen is active: menu, play, stage complete, game over, all clear.
- Tracks the current stage index.
- Issues level-load and sub-screen reset pulses.
- Muxes the active screen's rgb to the VGA output.
- Applies a hold-off window after every screen change so the key pulse that caused the change cannot also act on the new screen.

Parameters:
- NUM_STAGES, 3, number of stages; range 1..4.
- HOLDOFF, 2500000, cycles that inputs are ignored after each state entry; minimum 1.
- HW, 22, hold-off counter width; must satisfy 2^HW > HOLDOFF.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- key_pulse  in  5  one-cycle key code; 5'h1d = select, 5'h1e = move, other values = none
- stage_clear  in  1  one-cycle pulse from play logic: stage finished
- game_over  in  1  one-cycle pulse from play logic: player died
- complete_sel  in  2  from the stage-complete screen; 00 restart, 01 menu, 10 next, 11 none
- rgb_menu, rgb_play, rgb_complete, rgb_over, rgb_clear  in  3 each  per-screen pixel colour
- screen  out  3  registered state code
- stage  out  2  registered current stage index, 0-based
- stage_load  out  1  one-cycle pulse: load or restart the level for `stage`
- sub_rst  out  1  active-high one-cycle reset to the newly entered screen's cursor logic
- rgb  out  3  combinational mux of the rgb input selected by `screen`

Behaviour:
- Screen codes: MENU=0, PLAY=1, COMPLETE=2, GAMEOVER=3, ALLCLEAR=4. Codes 5–7 are illegal and recover to MENU on the next clock.
- Reset (rst=0, async): screen=MENU, stage=0, stage_load=0, sub_rst=1, hold-off counter=HOLDOFF.
- First clock after reset release: sub_rst=0.
- Hold-off counter:
  - Loaded with HOLDOFF on every state change.
  - Otherwise decrements, saturating at 0.
  - `ready` = (counter==0).
  - key_pulse and complete_sel are ignored while !ready.
  - stage_clear and game_over are NOT gated by the hold-off.
- MENU: ready && key_pulse==1d -> PLAY, with stage<=0 and load.
- PLAY:
  - game_over -> GAMEOVER. If game_over and stage_clear arrive in the same cycle, game_over wins.
  - Otherwise stage_clear -> ALLCLEAR if stage==NUM_STAGES-1, else COMPLETE.
  - key_pulse is ignored in PLAY.
- COMPLETE, when ready:
  - complete_sel 00 -> PLAY, same stage, load.
  - complete_sel 01 -> MENU.
  - complete_sel 10 -> PLAY, stage<=stage+1, load.
  - complete_sel 11 -> stay.
  - "Next" on the last stage cannot occur (that case routes to ALLCLEAR). If it does occur, treat it as restart.
- GAMEOVER: ready && key_pulse==1d -> MENU.
- ALLCLEAR: ready && key_pulse==1d -> MENU; stage<=0.
- "load" means: stage_load=1 in the cycle after the transition edge, i.e. in the same cycle screen first reads PLAY with the updated stage.
- sub_rst=1 for exactly one cycle after every state change, coincident with the new screen value.
- stage_clear and game_over outside PLAY are ignored.
- All outputs except rgb are registered. rgb is combinational from `screen`: illegal code -> 3'b000.

Decomposition:
- Package game_pkg holds:
  - screen codes (SCR_MENU..SCR_ALLCLEAR);
  - key codes KEY_SEL=5'h1d and KEY_MOVE=5'h1e;
  - complete_sel codes SEL_RESTART, SEL_MENU, SEL_NEXT, SEL_NONE.
- Sub-module holdoff_timer (params HOLDOFF, HW; ports clk, rst, load, ready) holds the reload/decrement counter.
- FSM, stage register and rgb mux stay in game_flow_ctrl.

Test Plan (HOLDOFF=4, NUM_STAGES=3):
- Reset, then key_pulse=1d at cycle 2 -> ignored, screen stays 0. key_pulse=1d at cycle 6 -> screen=1, stage=0; stage_load=1 and sub_rst=1 for one cycle.
- In PLAY stage 0: stage_clear -> screen=2. complete_sel=10 during hold-off -> ignored. complete_sel=10 after 4 cycles -> screen=1, stage=1, stage_load pulse.
- stage 1: stage_clear -> COMPLETE. complete_sel=00 -> PLAY, stage=1, stage_load pulse. Repeat with 01 -> screen=0, stage unchanged, no stage_load.
- stage 2: stage_clear -> screen=4. key 1d after hold-off -> screen=0, stage=0.
- PLAY: game_over and stage_clear in the same cycle -> screen=3. Key 1d after hold-off -> screen=0.
- Mid-PLAY rst low for 1 cycle (asynchronous) -> immediately screen=0, stage=0, stage_load=0, sub_rst=1. With screen driven to each code, rgb equals the matching rgb_* input.
